// File: rtl/run_det_pkg.sv
// Shared state codes and mode constants for the run detector.
// Imported by the run_length_detector top level.
package run_det_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN0 = 3'd1,
    RUN1 = 3'd2,
    HIT0 = 3'd3,
    HIT1 = 3'd4
  } state_e;

  localparam logic MODE_SUSTAIN = 1'b0;
  localparam logic MODE_PULSE   = 1'b1;

  function automatic state_e run_of(input logic b);
    return b ? RUN1 : RUN0;
  endfunction

endpackage

// File: rtl/run_length_detector_wrap_counter.sv
// Wrapping up-counter with synchronous clear and increment enable.
// Ports: clk, clr_i (sync clear), inc_i (increment), cnt_o (count).
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_length_detector.sv
// Detects RUN_LEN equal enabled samples of w; sustain or pulse flags.
// Ports: clk, aclr, en, w, mode in; z0, z1, z, run_cnt, event_cnt, state out.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       en,
  input  logic                       w,
  input  logic                       mode,
  output logic                       z0,
  output logic                       z1,
  output logic                       z,
  output logic [$clog2(RUN_LEN+1)-1:0] run_cnt,
  output logic [CNT_W-1:0]           event_cnt,
  output logic [2:0]                 state
);

  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] LEN    = CW'(RUN_LEN);
  localparam logic [CW-1:0] LEN_M1 = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z0_q, z1_q;
  logic          hit_entry;
  logic          run_bit;

  assign run_bit = (state_q == RUN1) || (state_q == HIT1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = run_of(w);
          cnt_d   = ONE;
        end
      end
      RUN0, RUN1: begin
        if (en) begin
          if (w != run_bit) begin
            state_d = run_of(w);
            cnt_d   = ONE;
          end else if (cnt_q == LEN_M1) begin
            state_d   = run_bit ? HIT1 : HIT0;
            cnt_d     = LEN;
            hit_entry = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      HIT0, HIT1: begin
        if (en) begin
          if (w != run_bit) begin
            state_d = run_of(w);
            cnt_d   = ONE;
          end else if (mode == MODE_PULSE) begin
            // a fresh block of the same value begins with this sample
            state_d = run_of(run_bit);
            cnt_d   = ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z0_q    <= 1'b0;
      z1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z0_q    <= (state_d == HIT0);
      z1_q    <= (state_d == HIT1);
    end
  end

  wrap_counter #(
    .W(CNT_W)
  ) u_evt (
    .clk  (clk),
    .clr_i(aclr),
    .inc_i(hit_entry),
    .cnt_o(event_cnt)
  );

  assign z0      = z0_q;
  assign z1      = z1_q;
  assign z       = z0_q | z1_q;
  assign run_cnt = cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector (RUN_LEN=4; CNT_W=8 and 2).
// Expected outputs queued at drive time, popped after each edge.
module tb_run_length_detector;

  localparam int RL = 4;

  logic       clk = 1'b0;
  logic       aclr, en, w, mode;
  logic       z0, z1, z;
  logic [2:0] run_cnt;
  logic [7:0] event_cnt;
  logic [2:0] state;
  logic       b_z0, b_z1, b_z;
  logic [2:0] b_run_cnt;
  logic [1:0] b_event_cnt;
  logic [2:0] b_state;

  typedef struct {
    logic       z0;
    logic       z1;
    logic [2:0] rc;
    logic [7:0] ev;
    logic [1:0] ev2;
    logic [2:0] st;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  bit   m_valid, m_b, m_hit;
  int   m_k, m_ev;

  always #5 clk = ~clk;

  run_length_detector #(.RUN_LEN(RL), .CNT_W(8)) dut (
    .clk(clk), .aclr(aclr), .en(en), .w(w), .mode(mode),
    .z0(z0), .z1(z1), .z(z), .run_cnt(run_cnt),
    .event_cnt(event_cnt), .state(state)
  );

  run_length_detector #(.RUN_LEN(RL), .CNT_W(2)) dut2 (
    .clk(clk), .aclr(aclr), .en(en), .w(w), .mode(mode),
    .z0(b_z0), .z1(b_z1), .z(b_z), .run_cnt(b_run_cnt),
    .event_cnt(b_event_cnt), .state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input bit r, input bit e,
                                input bit d, input bit md);
    if (r) begin
      m_valid = 0; m_hit = 0; m_k = 0; m_ev = 0;
    end else if (e) begin
      if (!m_valid || d != m_b) begin
        m_valid = 1; m_b = d; m_k = 1; m_hit = 0;
      end else if (m_hit) begin
        if (md) begin m_k = 1; m_hit = 0; end
      end else begin
        m_k++;
        if (m_k == RL) begin m_hit = 1; m_ev++; end
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t x;
    x.z0  = m_valid && m_hit && !m_b;
    x.z1  = m_valid && m_hit && m_b;
    x.rc  = m_valid ? 3'(m_k) : 3'd0;
    x.ev  = 8'(m_ev % 256);
    x.ev2 = 2'(m_ev % 4);
    x.st  = !m_valid ? 3'd0 :
            m_hit ? (m_b ? 3'd4 : 3'd3) : (m_b ? 3'd2 : 3'd1);
    return x;
  endfunction

  task automatic step(input bit r, input bit e, input bit d, input bit md);
    exp_t x;
    aclr = r; en = e; w = d; mode = md;
    model(r, e, d, md);
    q.push_back(predict());
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("z0", z0, x.z0);
    chk("z1", z1, x.z1);
    chk("z", z, x.z0 | x.z1);
    chk("run_cnt", run_cnt, x.rc);
    chk("event_cnt", event_cnt, x.ev);
    chk("state", state, x.st);
    chk("ev_w2", b_event_cnt, x.ev2);
  endtask

  initial begin
    bit d, md;
    aclr = 1; en = 0; w = 0; mode = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_ev", event_cnt, 0);
    // sustain run of zeros then a one
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    chk("sus_z0", z0, 1);
    chk("sus_ev", event_cnt, 1);
    step(0, 1, 1, 0);
    chk("sus_end_z0", z0, 0);
    chk("sus_end_rc", run_cnt, 1);
    // pulse mode ones
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1);
    chk("pulse_ev", event_cnt, 2);
    // alternating
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1'(i), 0);
    chk("alt_ev", event_cnt, 0);
    // gated enable
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1'(i % 2 == 0), 0, 0);
    chk("gate_z0", z0, 1);
    // reset mid-run
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("mid_rc", run_cnt, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("mid_z0", z0, 0);
    // counter wrap on the 2-bit instance
    step(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1);
    chk("wrap2", b_event_cnt, 1);
    chk("wrap8", event_cnt, 5);
    // random mix with long runs
    d = 0; md = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 2) d = ~d;
      if ($urandom_range(0, 19) == 0) md = ~md;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, d, md);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
